fir_transposed_prog: RTL and testbench
======================================

// Module: fir_transposed_prog
// PURPOSE
//  Parametrised transposed-form FIR with run-time programmable coefficients and a valid/ready stream interface.
//  Successor to the fixed-coefficient MCM filter. Adds generic tap count and widths, a coefficient write port,
//  backpressure, flush and optional saturation. Sits between the sample source and the output/feedback adder in
//  the filter top.
// PARAMETERS
//  DATA_W    32  sample width, signed in and out
//  COEF_W    16  coefficient width, signed
//  NTAPS     11  number of taps (>=2)
//  FRAC_BITS  8  arithmetic right shift applied to the accumulator before output
// PORTS
//  clk        in   1                clock, rising edge
//  reset      in   1                async active-low reset
//  in_valid   in   1                sample present
//  in_ready   out  1                block can accept a sample
//  in_data    in   DATA_W           signed sample
//  out_valid  out  1                result present
//  out_ready  in   1                consumer takes result
//  out_data   out  DATA_W           signed filtered result
//  coef_we    in   1                coefficient write strobe
//  coef_addr  in   clog2(NTAPS)     tap index
//  coef_data  in   COEF_W           signed coefficient
//  flush      in   1                sync clear of delay line and output
// BEHAVIOUR
//  - Reset: all tap regs z[k], coefficients c[k], out_data and out_valid = 0. in_ready comb = ~out_valid | out_ready.
//  - Accept = in_valid & in_ready. Delay line and output update only on accept; otherwise everything holds.
//  - On accept of x:
//      y     = c[0]*x + z[1]
//      z[k] <= c[k]*x + z[k+1]   for 1 <= k < NTAPS-1
//      z[NTAPS-1] <= c[NTAPS-1]*x
//    out_data <= y >>> FRAC_BITS, narrowed to DATA_W. out_valid <= 1.
//  - Latency: result valid the cycle after accept. Throughput is 1 sample/clk while out_ready is high.
//  - out_valid clears on out_ready when no new accept occurs. Accept with out_ready high gives back-to-back valid.
//  - Arithmetic: products DATA_W+COEF_W, accumulator ACC_W = DATA_W+COEF_W+clog2(NTAPS), all signed, no
//    intermediate truncation.
//  - Coef write: c[coef_addr] <= coef_data at the clock edge. coef_addr >= NTAPS is ignored. A write in the same
//    cycle as an accept: that accept uses the OLD value and the new value applies from the next accept. Pipeline
//    contents are not recomputed.
//  - flush: clears z[*], out_valid and out_data. Coefficients are kept. Accept is blocked that cycle
//    (in_ready = 0). flush wins over a simultaneous accept.
//  - Reset mid-stream: immediate clear of all state incl. coefficients. The first accept after release sees z = 0.
// CONFIGURATION
//  FIR_SAT_EN defined: the shifted result is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Undefined: two's-complement wrap (low DATA_W bits), matching legacy behaviour.
// STRUCTURE
//  Package fir_pkg: ACC_W/product-width functions, clog2 helper, saturate function, default widths.
//  Sub-module fir_tap_cell: one multiply-add-register stage (c*x + z_in, enable, flush), generated NTAPS-1 times.
//  The top holds the coefficient file, handshake and output stage.
// TESTING
//  1. Impulse: c = {1..11}, FRAC_BITS=0, feed 1 then zeros -> out 1,2,...,11 then 0. Each result 1 clk after accept.
//  2. Legacy set: c = {4,22,68,136,191,191,136,68,22,4,0}, FRAC_BITS=8, step x=256 -> out ramps to 842 and stays
//     there.
//  3. Backpressure: out_ready=0 with a result held -> in_ready=0, out_data stable. Release -> no sample lost or
//     duplicated across 20 random stalls.
//  4. Coef write same cycle as accept (c[0] 1->5, x=1, z=0) -> out 1. The next accept of x=1 gives 5 + prior z[1].
//  5. Flush mid-stream after 5 samples -> out_valid=0 next cycle. The next impulse gives a clean 1,2,3... response.
//     Coefs unchanged.
//  6. FIR_SAT_EN: c[0]=32767, x=0x7FFFFFFF, FRAC_BITS=0 -> out 0x7FFFFFFF. Without the macro -> low 32 bits of the
//     product.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, width helpers and saturation for the programmable FIR
package fir_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_COEF_W    = 16;
  localparam int DEF_NTAPS     = 11;
  localparam int DEF_FRAC_BITS = 8;
  // Widest accumulator the saturation helper handles
  localparam int MAX_W         = 128;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  function automatic int acc_w(input int data_w, input int coef_w, input int ntaps);
    return prod_w(data_w, coef_w) + clog2(ntaps);
  endfunction

  // Clamp a signed value to the range of a w-bit signed number
  function automatic logic signed [MAX_W-1:0] sat_to(input logic signed [MAX_W-1:0] v,
                                                     input int w);
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = '1;
    hi = hi >> (MAX_W - w + 1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_tap_cell.sv
// rtl/fir_tap_cell.sv - one transposed-form stage: z <= c*x + z_in on enable, cleared by flush
module fir_tap_cell #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 52
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  input  logic signed [ACC_W-1:0]  z_in,
  output logic signed [ACC_W-1:0]  z
);

  logic signed [ACC_W-1:0] prod;

  assign prod = ACC_W'(x) * ACC_W'(c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z <= '0;
    end else if (flush) begin
      z <= '0;
    end else if (en) begin
      z <= prod + z_in;
    end
  end

endmodule

// File: rtl/fir_transposed_prog.sv
// rtl/fir_transposed_prog.sv - transposed FIR with programmable coefficients and valid/ready stream
// FIR_SAT_EN defined: saturate the shifted result; otherwise wrap to DATA_W bits.
module fir_transposed_prog
  import fir_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int NTAPS     = DEF_NTAPS,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  input  logic                      coef_we,
  input  logic [clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      flush
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W, NTAPS);

  logic signed [COEF_W-1:0] coef [NTAPS];
  logic signed [ACC_W-1:0]  z    [1:NTAPS-1];
  logic signed [ACC_W-1:0]  p0;
  logic signed [ACC_W-1:0]  y;
  logic signed [ACC_W-1:0]  y_sh;
  logic signed [DATA_W-1:0] res;
  logic                     accept;

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Writes land at the edge, so an accept in the same cycle still multiplies by the old value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (coef_we && (32'(coef_addr) < NTAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  for (genvar k = 1; k < NTAPS; k++) begin : g_tap
    logic signed [ACC_W-1:0] z_in;
    if (k == NTAPS - 1) begin : g_last
      assign z_in = '0;
    end else begin : g_mid
      assign z_in = z[k+1];
    end
    fir_tap_cell #(
      .DATA_W(DATA_W),
      .COEF_W(COEF_W),
      .ACC_W (ACC_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .en   (accept),
      .flush(flush),
      .x    (in_data),
      .c    (coef[k]),
      .z_in (z_in),
      .z    (z[k])
    );
  end

  assign p0   = ACC_W'(in_data) * ACC_W'(coef[0]);
  assign y    = p0 + z[1];
  assign y_sh = y >>> FRAC_BITS;

`ifdef FIR_SAT_EN
  assign res = DATA_W'(sat_to(MAX_W'(y_sh), DATA_W));
`else
  assign res = DATA_W'(y_sh);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_transposed_prog.sv
// tb/tb_fir_transposed_prog.sv - self-checking bench: FRAC_BITS=0 and FRAC_BITS=8 instances, scoreboard plus vector tables
module tb_fir_transposed_prog;

  localparam int NT = 11;

  typedef struct {
    logic [31:0] x;
    logic [31:0] e0;
    logic [31:0] e8;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        flush = 1'b0;

  logic        in_ready0, in_ready8, out_valid0, out_valid8;
  logic [31:0] out_data0, out_data8;

  int          checks = 0;
  int          errors = 0;
  longint      mc [NT];
  longint      mz [NT+1];
  logic [31:0] q0 [$];
  logic [31:0] q8 [$];
  vec_t        tbl [$];
  int          cv [NT];

  always #5 clk = ~clk;

  fir_transposed_prog #(.DATA_W(32), .COEF_W(16), .NTAPS(NT), .FRAC_BITS(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush));

  fir_transposed_prog #(.DATA_W(32), .COEF_W(16), .NTAPS(NT), .FRAC_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .flush(flush));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt(input longint y, input int sh);
    longint s;
    s = y >>> sh;
`ifdef FIR_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) mc[k] = 0;
    for (int k = 0; k <= NT; k++) mz[k] = 0;
    q0.delete();
    q8.delete();
  endtask

  task automatic model_accept(input logic [31:0] x);
    longint xs;
    longint y;
    xs = longint'(signed'(x));
    y  = mc[0] * xs + mz[1];
    for (int k = 1; k < NT; k++) mz[k] = mc[k] * xs + mz[k+1];
    q0.push_back(fmt(y, 0));
    q8.push_back(fmt(y, 8));
  endtask

  // One clock: drive, check outputs mid-cycle against the scoreboard, advance the model, clock
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, input logic we,
                       input logic [3:0] a, input logic [15:0] cd, input logic fl);
    logic exp_valid;
    logic exp_rdy;
    in_valid = v; in_data = d; out_ready = ordy;
    coef_we = we; coef_addr = a; coef_data = cd; flush = fl;
    #2;
    exp_valid = (q0.size() != 0);
    exp_rdy   = !fl && (!exp_valid || ordy);
    check("out_valid0", 32'(out_valid0), 32'(exp_valid));
    check("out_valid8", 32'(out_valid8), 32'(exp_valid));
    check("in_ready0", 32'(in_ready0), 32'(exp_rdy));
    check("in_ready8", 32'(in_ready8), 32'(exp_rdy));
    if (exp_valid) begin
      check("sb_data0", out_data0, q0[0]);
      check("sb_data8", out_data8, q8[0]);
      if (ordy) begin
        void'(q0.pop_front());
        void'(q8.pop_front());
      end
    end
    if (fl) begin
      q0.delete();
      q8.delete();
      for (int k = 0; k <= NT; k++) mz[k] = 0;
    end else if (v && exp_rdy) begin
      model_accept(d);
    end
    if (we && a < 4'(NT)) mc[a] = longint'(signed'(cd));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic program_coefs();
    for (int k = 0; k < NT; k++) cycle(1'b0, '0, 1'b1, 1'b1, 4'(k), 16'(cv[k]), 1'b0);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].x, 1'b1, 1'b0, '0, '0, 1'b0);
      check({name, "_e0"}, out_data0, tbl[i].e0);
      check({name, "_e8"}, out_data8, tbl[i].e8);
    end
  endtask

  initial begin
    int pre;
    logic [31:0] sat_exp;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_data0", out_data0, 32'd0);
    check("rst_out_data8", out_data8, 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Impulse response with c = 1..11
    cv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    program_coefs();
    cycle(1'b0, '0, 1'b1, 1'b1, 4'd15, 16'd99, 1'b0);
    tbl.delete();
    tbl.push_back(vec_t'{32'd1, 32'd1, 32'd0});
    for (int k = 1; k < NT; k++) tbl.push_back(vec_t'{32'd0, 32'(k + 1), 32'd0});
    tbl.push_back(vec_t'{32'd0, 32'd0, 32'd0});
    tbl.push_back(vec_t'{32'd0, 32'd0, 32'd0});
    run_table("impulse");
    idle(2);

    // Flush mid-stream with a result held
    cycle(1'b1, 32'd1, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd0, 1'b1, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 32'd0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("flush_valid", 32'(out_valid0), 32'd0);
    check("flush_data", out_data0, 32'd0);
    cycle(1'b1, 32'd1, 1'b1, 1'b0, '0, '0, 1'b0);
    check("post_flush_1", out_data0, 32'd1);
    cycle(1'b1, 32'd0, 1'b1, 1'b0, '0, '0, 1'b0);
    check("post_flush_2", out_data0, 32'd2);
    cycle(1'b1, 32'd0, 1'b1, 1'b0, '0, '0, 1'b0);
    check("post_flush_3", out_data0, 32'd3);
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'd0, 1'b1, 1'b0, '0, '0, 1'b0);

    // Coefficient write coinciding with an accept
    cycle(1'b1, 32'd1, 1'b1, 1'b1, 4'd0, 16'd5, 1'b0);
    check("cw_old_coef", out_data0, 32'd1);
    cycle(1'b1, 32'd1, 1'b1, 1'b0, '0, '0, 1'b0);
    check("cw_new_coef", out_data0, 32'd7);
    idle(2);

    // Legacy coefficient set, step input
    cv = '{4, 22, 68, 136, 191, 191, 136, 68, 22, 4, 0};
    program_coefs();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
    tbl.delete();
    pre = 0;
    for (int k = 0; k < 14; k++) begin
      if (k < NT) pre += cv[k];
      tbl.push_back(vec_t'{32'd256, 32'(pre * 256), 32'(pre)});
    end
    run_table("legacy");
    idle(2);

    // Backpressure: hold, offer while stalled, then random stalls
    cycle(1'b1, 32'd100, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd555, 1'b0, 1'b0, '0, '0, 1'b0);
    check("bp_stall_rdy", 32'(in_ready0), 32'd0);
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 2000)) - 32'd1000,
            1'($urandom_range(0, 3) != 0), 1'b0, '0, '0, 1'b0);
    idle(3);

    // Overflow boundary: saturate or wrap depending on build
    cv = '{32767, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    program_coefs();
    cycle(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1);
`ifdef FIR_SAT_EN
    sat_exp = 32'h7FFFFFFF;
`else
    sat_exp = 32'h7FFF8001;
`endif
    cycle(1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, '0, '0, 1'b0);
    check("sat_pos", out_data0, sat_exp);
    cycle(1'b1, 32'h80000000, 1'b1, 1'b0, '0, '0, 1'b0);
    check("sat_neg", out_data0, 32'h80000000);
    idle(2);

    // Asynchronous reset mid-stream clears everything including coefficients
    cv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    program_coefs();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'd1000, 1'b1, 1'b0, '0, '0, 1'b0);
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid0), 32'd0);
    check("mid_rst_data", out_data0, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 32'd5, 1'b1, 1'b0, '0, '0, 1'b0);
    check("rst_coef_clr_v", 32'(out_valid0), 32'd1);
    check("rst_coef_clr_d", out_data0, 32'd0);
    program_coefs();
    cycle(1'b1, 32'd7, 1'b1, 1'b0, '0, '0, 1'b0);
    check("rst_first_acc", out_data0, 32'd7);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
